// File: rtl/slice_cfg_loader.sv
// slice_cfg_loader: streams a byte bitstream into an array of LUT slices.
// The stream is 0xA5, then one little-endian frame per slice, then an XOR
// checksum of all frame bytes. The fabric enable is raised only when the
// checksum matches.
// Optional build macro SLICE_CFG_TIMEOUT_EN adds an idle watchdog that
// aborts a stalled load with err_code 2'b10.
module slice_cfg_loader #(
  parameter int NUM_SLICES     = 4,
  parameter int LUT_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [7:0]              cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [NUM_SLICES-1:0]   slice_we,
  output logic [2*LUT_BITS-1:0]   slice_data,
  output logic                    fabric_en,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code
);

  localparam int FrameBits  = 2 * LUT_BITS;
  localparam int FrameBytes = FrameBits / 8;
  localparam int IdxW       = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int ByteW      = (FrameBytes > 1) ? $clog2(FrameBytes) : 1;

  localparam logic [7:0]       Header   = 8'hA5;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_SLICES - 1);
  localparam logic [ByteW-1:0] LastByte = ByteW'(FrameBytes - 1);

  // Reject parameter sets the frame packing or watchdog cannot represent
  if ((FrameBits % 8) != 0 || FrameBytes < 1 || TIMEOUT_CYCLES < 1) begin : gBadParams
    $error("slice_cfg_loader: LUT_BITS must give whole bytes and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LOAD,
    WRITE,
    CHECK,
    DONE,
    ERR
  } stateT;

  stateT                state;
  stateT                nextState;
  logic [FrameBits-1:0] frameReg;
  logic [FrameBits-1:0] frameNext;
  logic [FrameBits-1:0] sliceData;
  logic [7:0]           checksum;
  logic [IdxW-1:0]      sliceIdx;
  logic [ByteW-1:0]     byteCount;
  logic [1:0]           errReason;
  logic                 accept;
  logic                 timeoutHit;

  assign accept = cfg_valid && cfg_ready;

  // New bytes enter at the top so the first byte of a frame ends up in bits [7:0]
  assign frameNext = FrameBits'({cfg_data, frameReg} >> 8);

`ifdef SLICE_CFG_TIMEOUT_EN
  localparam int IdleW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IdleW-1:0] idleCount;

  // Count consecutive cycles without an accepted byte while the controller waits for data
  always_ff @(posedge CLK) begin
    if (RST) begin
      idleCount <= '0;
    end else if (accept || !cfg_ready || (nextState != state)) begin
      idleCount <= '0;
    end else begin
      idleCount <= idleCount + IdleW'(1);
    end
  end

  assign timeoutHit = cfg_ready && !accept && (idleCount == IdleW'(TIMEOUT_CYCLES - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode: start is only honoured once a load has finished or before any load
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) nextState = SYNC;
      end
      SYNC: begin
        if (accept && (cfg_data == Header)) nextState = LOAD;
        else if (timeoutHit)                nextState = ERR;
      end
      LOAD: begin
        if (accept && (byteCount == LastByte)) nextState = WRITE;
        else if (timeoutHit)                   nextState = ERR;
      end
      WRITE: begin
        nextState = (sliceIdx == LastIdx) ? CHECK : LOAD;
      end
      CHECK: begin
        if (accept)          nextState = (cfg_data == checksum) ? DONE : ERR;
        else if (timeoutHit) nextState = ERR;
      end
      default: nextState = IDLE;
    endcase
  end

  // Frame assembly, running checksum, slice index and error cause
  always_ff @(posedge CLK) begin
    if (RST) begin
      frameReg  <= '0;
      sliceData <= '0;
      checksum  <= '0;
      sliceIdx  <= '0;
      byteCount <= '0;
      errReason <= 2'b00;
    end else begin
      case (state)
        SYNC: begin
          if (accept && (cfg_data == Header)) begin
            sliceIdx  <= '0;
            byteCount <= '0;
            checksum  <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            frameReg <= frameNext;
            checksum <= checksum ^ cfg_data;
            if (byteCount == LastByte) begin
              byteCount <= '0;
              sliceData <= frameNext;
            end else begin
              byteCount <= byteCount + ByteW'(1);
            end
          end
        end
        WRITE: begin
          sliceIdx <= sliceIdx + IdxW'(1);
        end
        CHECK: begin
          if (accept && (cfg_data != checksum)) errReason <= 2'b01;
        end
        default: begin
        end
      endcase
      if (timeoutHit) errReason <= 2'b10;
    end
  end

  // Outputs are decoded from the state so reset and restart clear them together
  always_comb begin
    cfg_ready = (state == SYNC) || (state == LOAD) || (state == CHECK);
    slice_we  = (state == WRITE) ? (NUM_SLICES'(1) << sliceIdx) : '0;
    fabric_en = (state == DONE);
    done      = (state == DONE);
    error     = (state == ERR);
    err_code  = (state == ERR) ? errReason : 2'b00;
  end

  assign slice_data = sliceData;

endmodule

// File: tb/tb_slice_cfg_loader.sv
// tb_slice_cfg_loader: directed bench for slice_cfg_loader with hand-computed
// frames (payload 0x01..0x10 gives frames 0x04030201..0x100F0E0D, XOR 0x10).
module tb_slice_cfg_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  slice_we;
  logic [31:0] slice_data;
  logic        fabric_en;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic [3:0]  weLog[$];
  logic [31:0] dataLog[$];
  int          readyClashes = 0;

  logic [3:0]  expWe[4]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [31:0] expData[4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

  slice_cfg_loader #(
    .NUM_SLICES(4),
    .LUT_BITS(16),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .slice_we(slice_we),
    .slice_data(slice_data),
    .fabric_en(fabric_en),
    .done(done),
    .error(error),
    .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  // Record every write strobe and note any strobe seen while cfg_ready is high
  always @(negedge CLK) begin
    if (slice_we !== 4'b0000) begin
      weLog.push_back(slice_we);
      dataLog.push_back(slice_data);
      if (cfg_ready !== 1'b0) readyClashes++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit taken;
    taken = 1'b0;
    cfg_data  = b;
    cfg_valid = 1'b1;
    for (int i = 0; i < 200 && !taken; i++) begin
      taken = (cfg_ready === 1'b1);
      tick();
    end
    cfg_valid = 1'b0;
    checks++;
    if (!taken) begin
      errors++;
      $display("[TB] FAIL sendByte %02h: cfg_ready stayed 0, required 1", b);
    end
  endtask

  task automatic sendPayload(input int lo, input int hi, input int gap);
    for (int b = lo; b <= hi; b++) begin
      sendByte(8'(b));
      if (gap != 0 && (b % gap) == 0) repeat ((b % 3) + 1) tick();
    end
  endtask

  task automatic waitEnd();
    for (int i = 0; i < 50 && !(done === 1'b1 || error === 1'b1); i++) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    tick();
    tick();
    checks++;
    if ({cfg_ready, slice_we, fabric_en, done, error, err_code} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset outputs: got rdy=%b we=%b en=%b done=%b err=%b code=%b, required all 0",
               cfg_ready, slice_we, fabric_en, done, error, err_code);
    end
    checks++;
    if (slice_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset slice_data: got %h, required 00000000", slice_data);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle cfg_ready: got %b, required 0", cfg_ready);
    end
  endtask

  task automatic test_basic_load();
    int base;
    base = weLog.size();
    pulseStart();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sync cfg_ready: got %b, required 1", cfg_ready);
    end
    sendByte(8'hA5);
    sendPayload(1, 16, 0);
    sendByte(8'h10);
    waitEnd();
    checks++;
    if (weLog.size() - base !== 4) begin
      errors++;
      $display("[TB] FAIL basic strobe count: got %0d, required 4", weLog.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      if (base + i < weLog.size()) begin
        checks++;
        if (weLog[base+i] !== expWe[i] || dataLog[base+i] !== expData[i]) begin
          errors++;
          $display("[TB] FAIL basic strobe %0d: got we=%b data=%h, required we=%b data=%h",
                   i, weLog[base+i], dataLog[base+i], expWe[i], expData[i]);
        end
      end
    end
    checks++;
    if ({done, fabric_en, error, err_code, cfg_ready} !== 6'b110000) begin
      errors++;
      $display("[TB] FAIL basic result: got done=%b en=%b err=%b code=%b rdy=%b, required 1 1 0 00 0",
               done, fabric_en, error, err_code, cfg_ready);
    end
  endtask

  task automatic test_junk_before_header();
    int base;
    pulseStart();
    checks++;
    if ({fabric_en, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL restart drop: got en=%b done=%b, required 0 0", fabric_en, done);
    end
    base = weLog.size();
    sendByte(8'h00);
    sendByte(8'hFF);
    sendByte(8'h5A);
    checks++;
    if (weLog.size() !== base) begin
      errors++;
      $display("[TB] FAIL junk strobes: got %0d strobes, required 0", weLog.size() - base);
    end
    sendByte(8'hA5);
    sendPayload(1, 16, 0);
    sendByte(8'h10);
    waitEnd();
    checks++;
    if (weLog.size() - base !== 4) begin
      errors++;
      $display("[TB] FAIL junk strobe count: got %0d, required 4", weLog.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      if (base + i < weLog.size()) begin
        checks++;
        if (weLog[base+i] !== expWe[i] || dataLog[base+i] !== expData[i]) begin
          errors++;
          $display("[TB] FAIL junk strobe %0d: got we=%b data=%h, required we=%b data=%h",
                   i, weLog[base+i], dataLog[base+i], expWe[i], expData[i]);
        end
      end
    end
    checks++;
    if ({done, fabric_en, error, err_code} !== 5'b11000) begin
      errors++;
      $display("[TB] FAIL junk result: got done=%b en=%b err=%b code=%b, required 1 1 0 00",
               done, fabric_en, error, err_code);
    end
  endtask

  task automatic test_bad_checksum();
    int base;
    pulseStart();
    base = weLog.size();
    sendByte(8'hA5);
    sendPayload(1, 16, 0);
    sendByte(8'h11);
    waitEnd();
    checks++;
    if (weLog.size() - base !== 4) begin
      errors++;
      $display("[TB] FAIL badsum strobe count: got %0d, required 4", weLog.size() - base);
    end
    checks++;
    if ({error, err_code, done, fabric_en} !== 5'b10100) begin
      errors++;
      $display("[TB] FAIL badsum result: got err=%b code=%b done=%b en=%b, required 1 01 0 0",
               error, err_code, done, fabric_en);
    end
  endtask

  task automatic test_gaps();
    int base;
    int clashBase;
    pulseStart();
    base      = weLog.size();
    clashBase = readyClashes;
    sendByte(8'hA5);
    sendPayload(1, 16, 3);
    sendByte(8'h10);
    waitEnd();
    checks++;
    if (weLog.size() - base !== 4) begin
      errors++;
      $display("[TB] FAIL gaps strobe count: got %0d, required 4", weLog.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      if (base + i < weLog.size()) begin
        checks++;
        if (weLog[base+i] !== expWe[i] || dataLog[base+i] !== expData[i]) begin
          errors++;
          $display("[TB] FAIL gaps strobe %0d: got we=%b data=%h, required we=%b data=%h",
                   i, weLog[base+i], dataLog[base+i], expWe[i], expData[i]);
        end
      end
    end
    checks++;
    if (readyClashes - clashBase !== 0) begin
      errors++;
      $display("[TB] FAIL gaps ready during write: got %0d strobes with cfg_ready=1, required 0",
               readyClashes - clashBase);
    end
    checks++;
    if ({done, fabric_en} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL gaps result: got done=%b en=%b, required 1 1", done, fabric_en);
    end
  endtask

  task automatic test_reset_midload();
    int base;
    pulseStart();
    base = weLog.size();
    sendByte(8'hA5);
    sendPayload(1, 6, 0);
    RST = 1'b1;
    tick();
    checks++;
    if ({cfg_ready, slice_we, fabric_en, done, error, err_code} !== 10'b0 || slice_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midload reset: got rdy=%b we=%b en=%b done=%b err=%b code=%b data=%h, required all 0",
               cfg_ready, slice_we, fabric_en, done, error, err_code, slice_data);
    end
    RST = 1'b0;
    repeat (3) tick();
    checks++;
    if (weLog.size() - base !== 1) begin
      errors++;
      $display("[TB] FAIL midload strobes: got %0d, required 1", weLog.size() - base);
    end
    pulseStart();
    base = weLog.size();
    sendByte(8'hA5);
    sendPayload(1, 16, 0);
    sendByte(8'h10);
    waitEnd();
    checks++;
    if (weLog.size() - base !== 4 || {done, fabric_en, err_code} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL reload after reset: got strobes=%0d done=%b en=%b code=%b, required 4 1 1 00",
               weLog.size() - base, done, fabric_en, err_code);
    end
  endtask

  task automatic test_start_during_load();
    int base;
    pulseStart();
    base = weLog.size();
    sendByte(8'hA5);
    sendPayload(1, 2, 0);
    pulseStart();
    sendPayload(3, 16, 0);
    sendByte(8'h10);
    waitEnd();
    checks++;
    if (weLog.size() - base !== 4) begin
      errors++;
      $display("[TB] FAIL start-in-load strobe count: got %0d, required 4", weLog.size() - base);
    end
    if (weLog.size() - base >= 1) begin
      checks++;
      if (dataLog[base] !== 32'h04030201) begin
        errors++;
        $display("[TB] FAIL start-in-load frame0: got %h, required 04030201", dataLog[base]);
      end
    end
    checks++;
    if ({done, fabric_en} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL start-in-load result: got done=%b en=%b, required 1 1", done, fabric_en);
    end
    pulseStart();
    checks++;
    if ({fabric_en, done, error, cfg_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL start in done: got en=%b done=%b err=%b rdy=%b, required 0 0 0 1",
               fabric_en, done, error, cfg_ready);
    end
  endtask

  task automatic test_stall();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    pulseStart();
    sendByte(8'hA5);
    sendPayload(1, 6, 0);
    repeat (255) tick();
`ifdef SLICE_CFG_TIMEOUT_EN
    checks++;
    if ({error, err_code, fabric_en, done} !== 5'b11000) begin
      errors++;
      $display("[TB] FAIL stall timeout: got err=%b code=%b en=%b done=%b, required 1 10 0 0",
               error, err_code, fabric_en, done);
    end
`else
    checks++;
    if ({error, err_code, cfg_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL stall no timeout: got err=%b code=%b rdy=%b, required 0 00 1",
               error, err_code, cfg_ready);
    end
    sendPayload(7, 16, 0);
    sendByte(8'h10);
    waitEnd();
    checks++;
    if ({done, fabric_en, error} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL stall completion: got done=%b en=%b err=%b, required 1 1 0",
               done, fabric_en, error);
    end
`endif
  endtask

  // Run every scenario in order, then report
  initial begin
    RST       = 1'b1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    test_reset();
    test_basic_load();
    test_junk_before_header();
    test_bad_checksum();
    test_gaps();
    test_reset_midload();
    test_start_during_load();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a scenario never returns
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
